sdram_dma_engine: RTL and testbench

//   Parametrised Avalon-MM DMA master; successor to the single-word SDRAM copier.

---
 rtl/sdram_dma_engine.sv | 192 +++++++++++++++++++
 tb/tb_sdram_dma_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dma_engine.sv
// sdram_dma_engine
//   Avalon-MM DMA master. COPY mode streams num_words words from src_addr to
//   dst_addr with pipelined reads (at most FIFO_DEPTH words in flight or
//   buffered); FILL mode writes fill_value to num_words words at dst_addr.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start/mode/src_addr/dst_addr/num_words/fill_value
//                             job request, latched when start is seen in IDLE
//   busy, done, words_done    job status (done is a 1-cycle pulse)
//   master_*                  Avalon-MM master port toward the SDRAM controller
module sdram_dma_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_done,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(DATA_W / 8);
    localparam logic [PTR_W+1:0]   DEPTH_C = (PTR_W + 2)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]     FULL_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0]  num_q, num_d, words_done_q, words_done_d, reads_issued_q, reads_issued_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [PTR_W:0]    outstanding_q, outstanding_d, fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic              hold_q, hold_d, hold_wr_q, hold_wr_d;

    logic do_rd, do_wr, rd_acc, wr_acc, push, pop, wr_avail, rd_ok;
    logic [PTR_W+1:0]  occupancy;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    assign occupancy = (PTR_W + 2)'(outstanding_q) + (PTR_W + 2)'(fifo_count_q);
    assign wr_avail  = mode_q ? (words_done_q != num_q) : (fifo_count_q != '0);
    assign rd_ok     = !mode_q && (reads_issued_q != num_q) && (occupancy < DEPTH_C);
    assign rd_addr   = src_q + ADDR_W'(reads_issued_q) * STRIDE;
    assign wr_addr   = dst_q + ADDR_W'(words_done_q) * STRIDE;
    assign rd_acc    = do_rd && !master_waitrequest;
    assign wr_acc    = do_wr && !master_waitrequest;
    assign pop       = wr_acc && !mode_q;
    // Stray readdatavalid (e.g. from reads issued before a reset) finds no
    // outstanding read and is dropped.
    assign push      = master_readdatavalid && (outstanding_q != '0);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            num_q          <= '0;
            mode_q         <= 1'b0;
            fill_q         <= '0;
            words_done_q   <= '0;
            reads_issued_q <= '0;
            outstanding_q  <= '0;
            fifo_count_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            hold_q         <= 1'b0;
            hold_wr_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            assert (!(push && !pop && fifo_count_q == FULL_C));
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            num_q          <= num_d;
            mode_q         <= mode_d;
            fill_q         <= fill_d;
            words_done_q   <= words_done_d;
            reads_issued_q <= reads_issued_d;
            outstanding_q  <= outstanding_d;
            fifo_count_q   <= fifo_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            hold_q         <= hold_d;
            hold_wr_q      <= hold_wr_d;
            fifo_mem_q     <= fifo_mem_d;
        end
    end

    // Next state; DONE is entered right after the final write is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_words == '0) ? DONE : RUN;
            RUN:  if (wr_acc && (words_done_q + CNT_W'(1) == num_q)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command selection. A command stalled by waitrequest is re-issued as the
    // same type, so a read cannot be displaced by data arriving meanwhile.
    always_comb begin
        do_rd = 1'b0;
        do_wr = 1'b0;
        if (state_q == RUN) begin
            if (hold_q) begin
                do_wr = hold_wr_q;
                do_rd = !hold_wr_q;
            end else if (wr_avail) begin
                do_wr = 1'b1;
            end else if (rd_ok) begin
                do_rd = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        busy             = (state_q == RUN);
        done             = (state_q == DONE);
        words_done       = words_done_q;
        master_read      = do_rd;
        master_write     = do_wr;
        master_address   = do_wr ? wr_addr : (do_rd ? rd_addr : '0);
        master_writedata = do_wr ? (mode_q ? fill_q : fifo_mem_q[rd_ptr_q]) : '0;
    end

    // Datapath next values
    always_comb begin
        src_d          = src_q;
        dst_d          = dst_q;
        num_d          = num_q;
        mode_d         = mode_q;
        fill_d         = fill_q;
        words_done_d   = words_done_q;
        reads_issued_d = reads_issued_q;
        outstanding_d  = outstanding_q;
        fifo_count_d   = fifo_count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_mem_d     = fifo_mem_q;
        hold_d         = (do_rd || do_wr) && master_waitrequest;
        hold_wr_d      = do_wr;

        if (state_q == IDLE && start) begin
            src_d          = src_addr;
            dst_d          = dst_addr;
            num_d          = num_words;
            mode_d         = mode;
            fill_d         = fill_value;
            words_done_d   = '0;
            reads_issued_d = '0;
        end
        if (rd_acc) reads_issued_d = reads_issued_q + CNT_W'(1);
        if (wr_acc) words_done_d   = words_done_q + CNT_W'(1);

        case ({rd_acc, push})
            2'b10:   outstanding_d = outstanding_q + (PTR_W + 1)'(1);
            2'b01:   outstanding_d = outstanding_q - (PTR_W + 1)'(1);
            default: outstanding_d = outstanding_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + (PTR_W + 1)'(1);
            2'b01:   fifo_count_d = fifo_count_q - (PTR_W + 1)'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
        if (push) begin
            fifo_mem_d[wr_ptr_q] = master_readdata;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
endmodule

// File: tb/tb_sdram_dma_engine.sv
// Directed bench for sdram_dma_engine with a behavioural Avalon slave
// (fixed read latency, optional random waitrequest) and a bus monitor.
module tb_sdram_dma_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, num_words = '0, fill_value = '0;
    logic        busy, done;
    logic [31:0] words_done;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address, master_readdata, master_writedata;
    logic        master_read, master_readdatavalid, master_write;

    int n_checks = 0, n_errors = 0;

    sdram_dma_engine #(.DATA_W(32), .ADDR_W(32), .CNT_W(32), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_words(num_words),
        .fill_value(fill_value), .busy(busy), .done(done), .words_done(words_done),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_write(master_write),
        .master_writedata(master_writedata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // Slave: read data appears lat_cfg cycles after the accepting edge.
    int          lat_cfg = 2;
    logic        stall_en = 1'b0;
    logic        pv [8];
    logic [31:0] pd [8];
    initial for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    assign master_readdatavalid = pv[0];
    assign master_readdata      = pv[0] ? pd[0] : 32'hxxxx_xxxx;

    always @(posedge clk) begin
        logic        nv [8];
        logic [31:0] nd [8];
        for (int i = 0; i < 7; i++) begin nv[i] = pv[i+1]; nd[i] = pd[i+1]; end
        nv[7] = 1'b0; nd[7] = '0;
        if (master_read && !master_waitrequest) begin
            nv[lat_cfg-1] = 1'b1;
            nd[lat_cfg-1] = mem(master_address);
        end
        for (int i = 0; i < 8; i++) begin pv[i] <= nv[i]; pd[i] <= nd[i]; end
        master_waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: counts accepts, logs writes, tracks stall stability.
    int          cyc = 0, rd_acc_cnt, wr_acc_cnt, max_occ, first_rd, first_wr;
    int          done_cnt, busy_cnt, bus_cnt, stab_err;
    logic [31:0] wa_q[$], wd_q[$];
    logic        p_cmd = 1'b0, p_wait = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_a = '0, p_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (master_read && !master_waitrequest) begin
            rd_acc_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (master_write) begin
            if (first_wr < 0) first_wr = cyc;
            if (!master_waitrequest) begin
                wa_q.push_back(master_address);
                wd_q.push_back(master_writedata);
                wr_acc_cnt++;
            end
        end
        if (rd_acc_cnt - wr_acc_cnt > max_occ) max_occ = rd_acc_cnt - wr_acc_cnt;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (master_read || master_write) bus_cnt++;
        if (p_cmd && p_wait && (master_read !== p_rd || master_write !== p_wr ||
                                master_address !== p_a || master_writedata !== p_d))
            stab_err++;
        p_cmd = master_read || master_write; p_wait = master_waitrequest;
        p_rd = master_read; p_wr = master_write; p_a = master_address; p_d = master_writedata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_acc_cnt = 0; wr_acc_cnt = 0; max_occ = 0; first_rd = -1; first_wr = -1;
        done_cnt = 0; busy_cnt = 0; bus_cnt = 0; stab_err = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    task automatic kick(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] n, input logic [31:0] f);
        clear_mon();
        mode = m; src_addr = s; dst_addr = d; num_words = n; fill_value = f; start = 1'b1;
        step();
        // Later input changes must be ignored by the running job
        start = 1'b0; src_addr = 32'h0BAD_0000; dst_addr = 32'h0BAD_1000;
        num_words = 32'd99; fill_value = 32'h1111_1111; mode = ~m;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin step(); t++; end
        check({tag, "_timeout"}, 32'(t < 3000), 32'd1);
        step();
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] d0, input logic [31:0] n,
                                input logic fill, input logic [31:0] s0, input logic [31:0] fv);
        int bad = 0;
        check({tag, "_num_writes"}, 32'(wa_q.size()), n);
        for (int i = 0; i < wa_q.size() && i < int'(n); i++) begin
            if (wa_q[i] !== d0 + 32'(4 * i)) bad++;
            if (wd_q[i] !== (fill ? fv : mem(s0 + 32'(4 * i)))) bad++;
        end
        check({tag, "_write_addr_data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        clear_mon();
        step(); step();
        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words_done", words_done, 32'd0);
        check("rst_cmd", {30'd0, master_read, master_write}, 32'd0);
        check("rst_addr", master_address, 32'd0);
        check("rst_wdata", master_writedata, 32'd0);
        rst = 1'b0;
        step();

        // COPY 4 words, latency 2, no stalls
        lat_cfg = 2; stall_en = 1'b0;
        kick(1'b0, 32'h100, 32'h200, 32'd4, 32'h0);
        wait_done("copy4");
        check("copy4_w0_addr", wa_q[0], 32'h200);
        check("copy4_w3_addr", wa_q[3], 32'h20C);
        check("copy4_w0_data", wd_q[0], 32'hCAFE_0100);
        check("copy4_w3_data", wd_q[3], 32'hCAFE_010C);
        check("copy4_words_done", words_done, 32'd4);
        check("copy4_reads", 32'(rd_acc_cnt), 32'd4);
        check("copy4_latency", 32'(first_wr - first_rd), 32'd3);
        step();
        check("copy4_words_done_hold", words_done, 32'd4);

        // FILL 3 words
        kick(1'b1, 32'h0, 32'h40, 32'd3, 32'hDEAD_BEEF);
        wait_done("fill3");
        check("fill3_reads", 32'(rd_acc_cnt), 32'd0);
        check("fill3_w2_addr", wa_q[2], 32'h48);
        check("fill3_w1_data", wd_q[1], 32'hDEAD_BEEF);
        check_writes("fill3", 32'h40, 32'd3, 1'b1, 32'h0, 32'hDEAD_BEEF);
        check("fill3_words_done", words_done, 32'd3);

        // COPY 20 words, random stalls, latency 5
        lat_cfg = 5; stall_en = 1'b1;
        kick(1'b0, 32'h1000, 32'h8000, 32'd20, 32'h0);
        wait_done("copy20");
        stall_en = 1'b0;
        check_writes("copy20", 32'h8000, 32'd20, 1'b0, 32'h1000, 32'h0);
        check("copy20_reads", 32'(rd_acc_cnt), 32'd20);
        check("copy20_occ_le_8", 32'(max_occ <= 8), 32'd1);
        check("copy20_stall_stable", 32'(stab_err), 32'd0);
        check("copy20_words_done", words_done, 32'd20);

        // Zero-length job
        clear_mon();
        mode = 1'b0; num_words = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        step();
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_bus", 32'(bus_cnt), 32'd0);
        check("zero_busy_seen", 32'(busy_cnt), 32'd0);
        check("zero_words_done", words_done, 32'd0);

        // Reset mid-COPY with 3 reads in flight at the slave
        lat_cfg = 5; stall_en = 1'b0;
        kick(1'b0, 32'h500, 32'h900, 32'd8, 32'h0);
        for (int t = 0; t < 50 && rd_acc_cnt < 3; t++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd", {30'd0, master_read, master_write}, 32'd0);
        check("midrst_words_done", words_done, 32'd0);
        check("midrst_reads_before", 32'(rd_acc_cnt), 32'd3);
        clear_mon();
        for (int t = 0; t < 8; t++) step();
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_idle_bus", 32'(bus_cnt), 32'd0);
        lat_cfg = 2;
        kick(1'b0, 32'h600, 32'h700, 32'd2, 32'h0);
        wait_done("fresh2");
        check_writes("fresh2", 32'h700, 32'd2, 1'b0, 32'h600, 32'h0);
        check("fresh2_words_done", words_done, 32'd2);

        // Destination address wrap
        kick(1'b0, 32'h80, 32'hFFFF_FFF8, 32'd3, 32'h0);
        wait_done("wrap");
        check("wrap_a0", wa_q[0], 32'hFFFF_FFF8);
        check("wrap_a1", wa_q[1], 32'hFFFF_FFFC);
        check("wrap_a2", wa_q[2], 32'h0000_0000);
        check("wrap_d2", wd_q[2], 32'hCAFE_0088);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
